mips_control_fsm: RTL and testbench

// - Multicycle MIPS main controller. Sequences every instruction through FETCH/DECODE/execute states.
// - Drives datapath enables and mux selects. Drives the ALU's 3-bit alu_control via the alu_decoder sub-module.
// - Sits directly upstream of the ALU and consumes the ALU's zero flag for beq.

---
 rtl/mips_ctrl_pkg.sv | 128 ++++++++++++
 rtl/mips_control_fsm_alu_decoder.sv | 38 +++
 rtl/mips_control_fsm.sv | 123 ++++++++++++
 tb/tb_mips_control_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main controller:
//   - state_t      : FSM state encodings (S_FETCH .. S_JUMP)
//   - OP_*         : opcode field values (instr[31:26])
//   - FUNCT_*      : R-type funct field values (instr[5:0])
//   - ALU_*        : 3-bit alu_control codes driven to the ALU
//   - ALUOP_*      : 2-bit alu_op codes from the FSM to the ALU decoder
//   - ctrl_t       : bundle of state-decoded control signals
//   - state_ctrl() : Moore output decode for a given state
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore decode: every control except pc_en, illegal_op and alu_control
    // is a pure function of the state. Unused encodings drive everything low.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.i_or_d = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
                c.pc_src    = 2'b01;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_control_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the FSM's alu_op plus the instruction funct
// field into the ALU's 3-bit operation code.
//   alu_op      in  2  00 add, 01 sub, 10 use funct, 11 add
//   funct       in  6  instr[5:0]
//   alu_control out 3  010 add, 110 sub, 000 and, 001 or, 111 slt
// ---------------------------------------------------------------------------
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Unknown funct values and the spare alu_op code fall back to add so the
    // ALU never sees an undefined operation.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// ---------------------------------------------------------------------------
// mips_control_fsm
// Multicycle MIPS main controller. Steps each instruction through
// FETCH / DECODE / execute states and drives datapath enables and selects.
//   clk, reset         clock (rising edge) and async active-high reset
//   op, funct          opcode and funct fields from the instruction register
//   zero               ALU zero flag, used only in BRANCH
//   alu_control        ALU operation (via alu_decoder)
//   alu_src_a/b        ALU operand selects
//   i_or_d             memory address select
//   ir_write,mem_write,reg_write  write enables (forced low during reset)
//   reg_dst,mem_to_reg register-file write select / data select
//   pc_src, pc_en      next-PC select and PC load enable
//   illegal_op         one-cycle pulse when DECODE sees an unsupported op
//   state_o            current state encoding for debug
// ---------------------------------------------------------------------------
module mips_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   op_legal;

    // Opcode legality honours the build-time feature switches.
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ: op_legal = 1'b1;
            OP_ADDI: op_legal = ENABLE_ADDI;
            OP_J:    op_legal = ENABLE_JUMP;
            default: op_legal = 1'b0;
        endcase
    end

    // Next-state logic. Only DECODE and MEMADR look at the opcode; every
    // terminal state returns to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                if (op_legal) begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // State register plus registered Moore outputs: the controls are decoded
    // from the next state so they line up with state_q without extra logic
    // on the output path. Reset loads the FETCH decode; the write enables are
    // masked separately while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl_q.alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign i_or_d     = ctrl_q.i_or_d;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign pc_src     = ctrl_q.pc_src;
    assign state_o    = state_q;

    // Asserting reset mid-instruction must not let any architectural write
    // slip through, so every enable is gated directly by the reset pin.
    assign ir_write  = ctrl_q.ir_write  & ~reset;
    assign mem_write = ctrl_q.mem_write & ~reset;
    assign reg_write = ctrl_q.reg_write & ~reset;
    assign pc_en     = ~reset & (ctrl_q.pc_write | (ctrl_q.branch & zero));

    assign illegal_op = (state_q == S_DECODE) & ~op_legal;

endmodule

// File: tb/tb_mips_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_control_fsm
// Drives two controller instances (full feature set, and addi/j disabled)
// with directed and random instructions. Expected per-cycle outputs are
// derived from instruction-level rules and queued; a negedge monitor pops
// and compares whenever an expectation is pending.
// ---------------------------------------------------------------------------
module tb_mips_control_fsm;

    typedef struct packed {
        logic [3:0] state;
        logic [2:0] aluc;
        logic       srcA;
        logic [1:0] srcB;
        logic       iOrD;
        logic       irW;
        logic       memW;
        logic       regW;
        logic       regDst;
        logic       memToReg;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic       illegal;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] opA, functA, opB, functB;
    logic zeroA, zeroB;

    logic [2:0] alucA, alucB;
    logic srcAA, srcAB, iOrDA, iOrDB, irWA, irWB, memWA, memWB, regWA, regWB;
    logic regDstA, regDstB, memToRegA, memToRegB, pcEnA, pcEnB, illA, illB;
    logic [1:0] srcBA, srcBB, pcSrcA, pcSrcB;
    logic [3:0] stateA, stateB;

    obs_t actA, actB;
    obs_t expA[$];
    obs_t expB[$];

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    mips_control_fsm dutA (
        .clk(clk), .reset(reset), .op(opA), .funct(functA), .zero(zeroA),
        .alu_control(alucA), .alu_src_a(srcAA), .alu_src_b(srcBA),
        .i_or_d(iOrDA), .ir_write(irWA), .mem_write(memWA), .reg_write(regWA),
        .reg_dst(regDstA), .mem_to_reg(memToRegA), .pc_src(pcSrcA),
        .pc_en(pcEnA), .illegal_op(illA), .state_o(stateA)
    );

    mips_control_fsm #(.ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0)) dutB (
        .clk(clk), .reset(reset), .op(opB), .funct(functB), .zero(zeroB),
        .alu_control(alucB), .alu_src_a(srcAB), .alu_src_b(srcBB),
        .i_or_d(iOrDB), .ir_write(irWB), .mem_write(memWB), .reg_write(regWB),
        .reg_dst(regDstB), .mem_to_reg(memToRegB), .pc_src(pcSrcB),
        .pc_en(pcEnB), .illegal_op(illB), .state_o(stateB)
    );

    assign actA = {stateA, alucA, srcAA, srcBA, iOrDA, irWA, memWA, regWA,
                   regDstA, memToRegA, pcSrcA, pcEnA, illA};
    assign actB = {stateB, alucB, srcAB, srcBB, iOrDB, irWB, memWB, regWB,
                   regDstB, memToRegB, pcSrcB, pcEnB, illB};

    // ALU operation an R-type instruction asks for, by funct value.
    function automatic logic [2:0] rTypeAlu(input logic [5:0] f);
        case (f)
            6'd32:   return 3'b010;
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd42:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Sequence of states an instruction visits, FETCH to last execute state.
    task automatic buildSeq(input logic [5:0] op, input bit enAddi, input bit enJump,
                            output int seq[$], output bit legal);
        seq.delete();
        seq.push_back(0);
        seq.push_back(1);
        legal = 1'b1;
        if (op == 6'd35) begin
            seq.push_back(2); seq.push_back(3); seq.push_back(4);
        end else if (op == 6'd43) begin
            seq.push_back(2); seq.push_back(5);
        end else if (op == 6'd0) begin
            seq.push_back(6); seq.push_back(7);
        end else if (op == 6'd4) begin
            seq.push_back(8);
        end else if (op == 6'd8 && enAddi) begin
            seq.push_back(9); seq.push_back(10);
        end else if (op == 6'd2 && enJump) begin
            seq.push_back(11);
        end else begin
            legal = 1'b0;
        end
    endtask

    // Outputs the datapath should see in a given step of an instruction.
    function automatic obs_t expectStep(input int st, input logic [5:0] f,
                                        input logic z, input bit legal);
        obs_t o;
        o = '0;
        o.state = st[3:0];
        o.aluc = 3'b010;
        case (st)
            0:  begin o.irW = 1; o.srcB = 2'b01; o.pcEn = 1; end
            1:  begin o.srcB = 2'b11; o.illegal = !legal; end
            2:  begin o.srcA = 1; o.srcB = 2'b10; end
            3:  o.iOrD = 1;
            4:  begin o.regW = 1; o.memToReg = 1; end
            5:  begin o.iOrD = 1; o.memW = 1; end
            6:  begin o.srcA = 1; o.aluc = rTypeAlu(f); end
            7:  begin o.regDst = 1; o.regW = 1; end
            8:  begin o.srcA = 1; o.aluc = 3'b110; o.pcSrc = 2'b01; o.pcEn = z; end
            9:  begin o.srcA = 1; o.srcB = 2'b10; end
            10: o.regW = 1;
            11: begin o.pcSrc = 2'b10; o.pcEn = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic obs_t resetObs();
        obs_t o;
        o = '0;
        o.aluc = 3'b010;
        o.srcB = 2'b01;
        return o;
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s step=%0d got=%h want=%h", name, exp.state, act, exp);
        end
    endtask

    // Monitor: one comparison per cycle whenever an expectation is pending.
    always @(negedge clk) begin
        if (expA.size() > 0) checkOutput("dutA", actA, expA.pop_front());
        if (expB.size() > 0) checkOutput("dutB", actB, expB.pop_front());
    end

    // Runs one instruction (optionally only its first 'limit' cycles).
    // Entered and left just after a rising edge. zeroMode: 0/1 fixed, 2 random.
    task automatic applyStimulus(input bit useB, input logic [5:0] op,
                                 input logic [5:0] funct, input int zeroMode,
                                 input int limit);
        int seq[$];
        bit legal;
        logic zs[$];
        int n;
        buildSeq(op, !useB, !useB, seq, legal);
        n = (seq.size() < limit) ? seq.size() : limit;
        for (int i = 0; i < n; i++) begin
            logic z;
            z = (zeroMode == 2) ? logic'($urandom_range(0, 1)) : logic'(zeroMode == 1);
            zs.push_back(z);
            if (useB) expB.push_back(expectStep(seq[i], funct, z, legal));
            else      expA.push_back(expectStep(seq[i], funct, z, legal));
        end
        if (useB) begin opB = op; functB = funct; end
        else      begin opA = op; functA = funct; end
        for (int i = 0; i < n; i++) begin
            if (useB) zeroB = zs[i];
            else      zeroA = zs[i];
            @(posedge clk);
            #1;
        end
    endtask

    // Holds reset across one rising edge; both instances end up in FETCH.
    task automatic doReset();
        reset = 1'b1;
        expA.push_back(resetObs());
        expB.push_back(resetObs());
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic randomInstr(input bit useB);
        logic [5:0] op, f;
        case ($urandom_range(0, 7))
            0: op = 6'd0;
            1: op = 6'd35;
            2: op = 6'd43;
            3: op = 6'd4;
            4: op = 6'd8;
            5: op = 6'd2;
            default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0: f = 6'd32;
            1: f = 6'd34;
            2: f = 6'd36;
            3: f = 6'd37;
            4: f = 6'd42;
            default: f = 6'($urandom);
        endcase
        applyStimulus(useB, op, f, 2, 99);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1;
        opA = '0; functA = '0; zeroA = 1'b0;
        opB = '0; functB = '0; zeroB = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        // Directed instructions on the full-feature instance.
        applyStimulus(1'b0, 6'b100011, 6'd0, 2, 99);   // lw
        applyStimulus(1'b0, 6'b000000, 6'b101010, 2, 99); // slt
        applyStimulus(1'b0, 6'b000100, 6'd0, 1, 99);   // beq taken
        applyStimulus(1'b0, 6'b000100, 6'd0, 0, 99);   // beq not taken
        applyStimulus(1'b0, 6'b111111, 6'd0, 2, 99);   // illegal
        applyStimulus(1'b0, 6'b101011, 6'd0, 2, 99);   // sw
        applyStimulus(1'b0, 6'b001000, 6'd0, 2, 99);   // addi
        applyStimulus(1'b0, 6'b000010, 6'd0, 2, 99);   // j

        // lw cut short in MEMWB by reset.
        applyStimulus(1'b0, 6'b100011, 6'd0, 2, 4);
        doReset();

        for (int i = 0; i < 200; i++) randomInstr(1'b0);

        // Reduced-feature instance: j and addi must decode as illegal.
        doReset();
        applyStimulus(1'b1, 6'b000010, 6'd0, 2, 99);
        applyStimulus(1'b1, 6'b001000, 6'd0, 2, 99);
        applyStimulus(1'b1, 6'b111111, 6'd0, 2, 99);
        applyStimulus(1'b1, 6'b100011, 6'd0, 2, 99);
        applyStimulus(1'b1, 6'b000100, 6'd0, 1, 99);
        for (int i = 0; i < 60; i++) randomInstr(1'b1);

        @(posedge clk);
        @(posedge clk);
        testsRun++;
        if (expA.size() != 0 || expB.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain pendingA=%0d pendingB=%0d want 0", expA.size(), expB.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
